// File: rtl/lsq_issue_arbiter_if.sv
// lsq_issue_arbiter_if: LQ/SQ/sub-unit handshake bundle for the memory-issue arbiter
interface lsq_issue_arbiter_if #(parameter int NUM_SUBUNITS = 4);
  localparam int SUB_W = NUM_SUBUNITS > 1 ? $clog2(NUM_SUBUNITS) : 1;
  logic                    lq_valid;
  logic [SUB_W-1:0]        lq_subunit;
  logic                    lq_store_conflict;
  logic                    lq_pop;
  logic                    sq_valid;
  logic [SUB_W-1:0]        sq_subunit;
  logic                    sq_has_paired_load;
  logic                    sq_pop;
  logic                    sq_no_released_pending;
  logic [NUM_SUBUNITS-1:0] subunit_ready;
  logic                    amo_done;
  logic                    fence_req;
  logic                    fence_done;
  logic                    issue_valid;
  logic                    issue_is_store;
  logic [SUB_W-1:0]        issue_subunit;
  modport master (
    output lq_valid, lq_subunit, lq_store_conflict, sq_valid, sq_subunit, sq_has_paired_load,
           sq_no_released_pending, subunit_ready, amo_done, fence_req,
    input  lq_pop, sq_pop, fence_done, issue_valid, issue_is_store, issue_subunit
  );
  modport slave (
    input  lq_valid, lq_subunit, lq_store_conflict, sq_valid, sq_subunit, sq_has_paired_load,
           sq_no_released_pending, subunit_ready, amo_done, fence_req,
    output lq_pop, sq_pop, fence_done, issue_valid, issue_is_store, issue_subunit
  );
endinterface

// File: rtl/lsq_issue_arbiter.sv
// lsq_issue_arbiter: load/store memory-issue slot arbiter with store starvation guard, AMO and fence sequencing
// Optional LSQ_ARB_PERF_EN adds saturating store-stall and fence-drain cycle counters.
module lsq_issue_arbiter #(
  parameter int NUM_SUBUNITS       = 4,
  parameter int STORE_STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  lsq_issue_arbiter_if.slave       bus
`ifdef LSQ_ARB_PERF_EN
  ,
  output logic [15:0]              perf_store_stall,
  output logic [15:0]              perf_fence_cycles
`endif
);
  localparam int SUB_W = NUM_SUBUNITS > 1 ? $clog2(NUM_SUBUNITS) : 1;
  localparam logic [3:0] LIMIT = 4'(STORE_STARVE_LIMIT);
  typedef enum logic [1:0] {NORMAL, AMO_WAIT, FENCE_DRAIN} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_starve;
  logic       r_fence_pend;
  logic       w_ld_ok, w_st_ok, w_st_win, w_lq_pop, w_sq_pop, w_fence_done;
  assign w_ld_ok  = bus.lq_valid & ~bus.lq_store_conflict & bus.subunit_ready[bus.lq_subunit];
  assign w_st_ok  = bus.sq_valid & bus.subunit_ready[bus.sq_subunit];
  assign w_st_win = w_st_ok & (~w_ld_ok | r_starve == LIMIT);
  always_comb begin
    w_next       = r_state;
    w_lq_pop     = 1'b0;
    w_sq_pop     = 1'b0;
    w_fence_done = 1'b0;
    if (!rst) begin
      case (r_state)
        NORMAL: begin
          w_sq_pop = w_st_win;
          w_lq_pop = w_ld_ok & ~w_st_win;
          w_next   = (w_sq_pop & bus.sq_has_paired_load) ? AMO_WAIT :
                     (bus.fence_req | r_fence_pend) ? FENCE_DRAIN : NORMAL;
        end
        AMO_WAIT: w_next = bus.amo_done ? ((r_fence_pend | bus.fence_req) ? FENCE_DRAIN : NORMAL) : AMO_WAIT;
        FENCE_DRAIN: begin
          w_sq_pop     = w_st_ok;
          w_fence_done = bus.sq_no_released_pending & ~bus.sq_valid;
          w_next       = (w_sq_pop & bus.sq_has_paired_load) ? AMO_WAIT :
                         w_fence_done ? NORMAL : FENCE_DRAIN;
        end
        default: w_next = NORMAL;
      endcase
    end
  end
  assign bus.lq_pop         = w_lq_pop;
  assign bus.sq_pop         = w_sq_pop;
  assign bus.fence_done     = w_fence_done;
  assign bus.issue_valid    = w_lq_pop | w_sq_pop;
  assign bus.issue_is_store = w_sq_pop;
  assign bus.issue_subunit  = w_sq_pop ? bus.sq_subunit : w_lq_pop ? bus.lq_subunit : SUB_W'(0);
  // A fence seen outside an active drain is remembered; an AMO issued mid-drain re-arms it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= NORMAL;
      r_starve     <= 4'd0;
      r_fence_pend <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_starve     <= w_sq_pop ? 4'd0 : (w_st_ok & w_lq_pop & r_starve < LIMIT) ? r_starve + 4'd1 : r_starve;
      r_fence_pend <= (w_next == FENCE_DRAIN && r_state != FENCE_DRAIN) ? 1'b0 :
                      r_fence_pend | (bus.fence_req && r_state != FENCE_DRAIN) |
                      (r_state == FENCE_DRAIN && w_next == AMO_WAIT);
    end
  end
`ifdef LSQ_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_store_stall  <= 16'd0;
      perf_fence_cycles <= 16'd0;
    end else begin
      perf_store_stall  <= (bus.sq_valid & ~w_sq_pop & ~&perf_store_stall) ? perf_store_stall + 16'd1 : perf_store_stall;
      perf_fence_cycles <= (r_state == FENCE_DRAIN && !(&perf_fence_cycles)) ? perf_fence_cycles + 16'd1 : perf_fence_cycles;
    end
  end
`endif
endmodule
